// File: rtl/db_ram_1p_arb.sv
// db_ram_1p_arb: two-requester arbiter/sequencer for one single-port deblocking SRAM
//   clk, rstn                          clock, async active-low reset
//   a_req_i/a_wen_i/a_addr_i/a_data_i  filter write-back / reread request (wen: 0 write, 1 read)
//   a_gnt_o, a_rvld_o                  A access issued this cycle, A read data on rdata_o
//   b_req_i/b_wen_i/b_addr_i/b_data_i  output fetch request
//   b_gnt_o, b_rvld_o                  B access issued this cycle, B read data on rdata_o
//   rdata_o                            shared read return, straight from the RAM
//   ram_cen_o/ram_oen_o/ram_wen_o      active-low RAM controls
//   ram_addr_o, ram_data_o, ram_data_i RAM address, write data, read data (1-cycle latency)
module db_ram_1p_arb #(
  parameter int WORD_WIDTH = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  a_req_i,
  input  logic                  a_wen_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [WORD_WIDTH-1:0] a_data_i,
  output logic                  a_gnt_o,
  output logic                  a_rvld_o,
  input  logic                  b_req_i,
  input  logic                  b_wen_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [WORD_WIDTH-1:0] b_data_i,
  output logic                  b_gnt_o,
  output logic                  b_rvld_o,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  ram_cen_o,
  output logic                  ram_oen_o,
  output logic                  ram_wen_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [WORD_WIDTH-1:0] ram_data_o,
  input  logic [WORD_WIDTH-1:0] ram_data_i
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       a_rvld_q, a_rvld_d, b_rvld_q, b_rvld_d, ram_oen_q, ram_oen_d;
  logic       b_starved;
  always_comb begin
    b_starved    = starve_cnt_q >= SMAX;
    // grants are gated by rstn so no access can reach the RAM while in reset
    a_gnt_o      = rstn & a_req_i & (~b_req_i | ~b_starved);
    b_gnt_o      = rstn & b_req_i & ~a_gnt_o;
    starve_cnt_d = (b_req_i & ~b_gnt_o) ? (b_starved ? SMAX : starve_cnt_q + 4'd1) : 4'd0;
    a_rvld_d     = a_gnt_o & a_wen_i;
    b_rvld_d     = b_gnt_o & b_wen_i;
    ram_oen_d    = ~(a_rvld_d | b_rvld_d);
    ram_cen_o    = ~(a_gnt_o | b_gnt_o);
    ram_wen_o    = b_gnt_o ? b_wen_i : a_gnt_o ? a_wen_i : 1'b1;
    ram_addr_o   = b_gnt_o ? b_addr_i : a_addr_i;
    ram_data_o   = b_gnt_o ? b_data_i : a_data_i;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt_q <= 4'd0;
      a_rvld_q     <= 1'b0;
      b_rvld_q     <= 1'b0;
      ram_oen_q    <= 1'b1;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      a_rvld_q     <= a_rvld_d;
      b_rvld_q     <= b_rvld_d;
      ram_oen_q    <= ram_oen_d;
    end
  end
  assign a_rvld_o  = a_rvld_q;
  assign b_rvld_o  = b_rvld_q;
  assign ram_oen_o = ram_oen_q;
  assign rdata_o   = ram_data_i;
endmodule
